// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared width defaults and requester index constants for the register-file
// write-back arbiter, plus a small modulo-increment helper.
//   REG_AW / REG_DW : default register address / data widths
//   WB_NREQ         : default number of write-back requesters
//   WB_ALU/MEM/MDU  : requester index of each write-back source
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned REG_DW  = 32;
    localparam int unsigned WB_NREQ = 3;

    localparam int unsigned WB_ALU = 0;
    localparam int unsigned WB_MEM = 1;
    localparam int unsigned WB_MDU = 2;

    // (idx + 1) mod n, for idx already in 0..n-1
    function automatic int unsigned wb_wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Round-robin priority picker. Scans the request vector starting at i_ptr,
// wrapping modulo NREQ, and grants the first set bit.
//   i_req   : request bits
//   i_ptr   : highest-priority index for this cycle
//   o_gnt   : one-hot grant (zero when nothing requested)
//   o_idx   : binary index of the granted request
//   o_found : some request was granted
// ---------------------------------------------------------------------------
module rr_pick
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = WB_NREQ,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [PW-1:0]   o_idx,
    output logic            o_found
);

    always_comb begin
        int unsigned w_pos;
        o_gnt   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (!o_found && i_req[w_pos[PW-1:0]]) begin
                o_found                = 1'b1;
                o_idx                  = w_pos[PW-1:0];
                o_gnt[w_pos[PW-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Shares the register file's single write port between NREQ write-back
// requesters. One round-robin grant per cycle; the granted {addr, data} is
// registered into a one-cycle write pulse. Writes to register 0 are consumed
// but never raise o_rf_we.
//
// Optional feature (macro RF_WB_BYPASS_EN): forward the in-flight write to
// the two read ports. Without the macro the read ports pass through.
//
// Ports:
//   i_clk, i_rst_n          : clock, async active-low reset
//   i_wb_en                 : low blocks all grants
//   i_req_valid/o_req_ready : per-requester handshake (ready is one-hot/zero)
//   i_req_addr/i_req_data   : packed per-requester address / data
//   o_rf_we/waddr/wdata     : registered register-file write port
//   i_rd_a1/a2, i_rf_rd1/2  : read addresses and raw read data
//   o_fwd_rd1/2             : read data after optional forwarding
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = WB_NREQ,
    parameter int unsigned DW   = REG_DW,
    parameter int unsigned AW   = REG_AW
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_wb_en,
    input  logic [NREQ-1:0]    i_req_valid,
    output logic [NREQ-1:0]    o_req_ready,
    input  logic [NREQ*AW-1:0] i_req_addr,
    input  logic [NREQ*DW-1:0] i_req_data,
    output logic               o_rf_we,
    output logic [AW-1:0]      o_rf_waddr,
    output logic [DW-1:0]      o_rf_wdata,
    input  logic [AW-1:0]      i_rd_a1,
    input  logic [AW-1:0]      i_rd_a2,
    input  logic [DW-1:0]      i_rf_rd1,
    input  logic [DW-1:0]      i_rf_rd2,
    output logic [DW-1:0]      o_fwd_rd1,
    output logic [DW-1:0]      o_fwd_rd2
);

    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;

    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_gnt;
    logic [PW-1:0]   w_idx;
    logic            w_found;
    logic [PW-1:0]   w_ptr_nxt;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    // Masking with reset keeps ready low while the block is held in reset.
    assign w_req = i_req_valid & {NREQ{i_wb_en & i_rst_n}};

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_gnt),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    assign o_req_ready = w_gnt;
    assign w_sel_addr  = i_req_addr[32'(w_idx) * AW +: AW];
    assign w_sel_data  = i_req_data[32'(w_idx) * DW +: DW];
    assign w_ptr_nxt   = PW'(wb_wrap_inc(32'(w_idx), NREQ));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_found) begin
            r_ptr   <= w_ptr_nxt;
            // Register 0 is hard-wired: transfer is consumed, write suppressed.
            r_we    <= (w_sel_addr != '0);
            r_waddr <= w_sel_addr;
            r_wdata <= w_sel_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign o_rf_we    = r_we;
    assign o_rf_waddr = r_waddr;
    assign o_rf_wdata = r_wdata;

`ifdef RF_WB_BYPASS_EN
    always_comb begin
        o_fwd_rd1 = i_rf_rd1;
        o_fwd_rd2 = i_rf_rd2;
        if (r_we && (i_rd_a1 == r_waddr) && (i_rd_a1 != '0)) begin
            o_fwd_rd1 = r_wdata;
        end
        if (r_we && (i_rd_a2 == r_waddr) && (i_rd_a2 != '0)) begin
            o_fwd_rd2 = r_wdata;
        end
    end
`else
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^{i_rd_a1, i_rd_a2};
    assign o_fwd_rd1        = i_rf_rd1;
    assign o_fwd_rd2        = i_rf_rd2;
`endif

endmodule
